angle_reduce: RTL and testbench

Pipelined range-reduction stage that sits directly upstream of the `sin` approximators in `sincos`. It takes an arbitrary Q19.16 joint angle and wraps it into [-π, π). It emits two phases: the wrapped angle for the sine path, and the wrapped angle + π/2 for the cosine path. Both outputs therefore always land in the validity range of the parabolic sine approximation.

---
 rtl/sincos_pkg.sv | 10 +
 rtl/wrap_pi.sv | 9 +
 rtl/angle_reduce.sv | 57 +++++
 tb/tb_angle_reduce.sv | 131 +++++++++++++
 4 files changed

// File: rtl/sincos_pkg.sv
// sincos_pkg: Q16 angle constants, q16_t angle type and LAT pipeline latency for the sincos datapath
package sincos_pkg;
  typedef logic signed [35:0] q16_t;
  localparam q16_t PI_Q = 36'sd205887;
  localparam q16_t TWO_PI_Q = 36'sd411775;
  localparam q16_t HALF_PI_Q = 36'sd102944;
  localparam q16_t INV_TWO_PI_Q = 36'sd10430;
  localparam q16_t RANGE_Q = 36'sd4194304;
  localparam int LAT = 6;
endpackage

// File: rtl/wrap_pi.sv
// wrap_pi: combinational single-step +/-TWO_PI_Q correction toward [-PI_Q, PI_Q); a in, y out
module wrap_pi
  import sincos_pkg::*;
(
  input  q16_t a,
  output q16_t y
);
  always_comb y = a >= PI_Q ? a - TWO_PI_Q : a < -PI_Q ? a + TWO_PI_Q : a;
endmodule

// File: rtl/angle_reduce.sv
// angle_reduce: 6-stage Q19.16 range reduction to [-pi,pi); clk/rst/en, in_valid+angle in, out_valid/sin_angle/cos_angle/out_range out
module angle_reduce
  import sincos_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic in_valid,
  input  q16_t angle,
  output logic out_valid,
  output q16_t sin_angle,
  output q16_t cos_angle,
  output logic out_range
);
  logic [36:0] p_q;
  q16_t a1_q, a2_q, a3_q, k, k_q, kt_q, r_q, rc, rc_q, c, cw;
  logic [5:0] v_q, g_q;
  logic rng;
  always_comb begin
    rng = angle > RANGE_Q || angle < -RANGE_Q;
    k = q16_t'(p_q[36:1] + 36'(p_q[0]));
    c = rc_q + HALF_PI_Q;
  end
  wrap_pi u_wrap_r (.a(r_q), .y(rc));
  wrap_pi u_wrap_c (.a(c), .y(cw));
  assign out_valid = v_q[5];
  assign out_range = g_q[5];
  always_ff @(posedge clk) begin
    if (rst) begin
      p_q <= '0;
      a1_q <= '0;
      a2_q <= '0;
      a3_q <= '0;
      k_q <= '0;
      kt_q <= '0;
      r_q <= '0;
      rc_q <= '0;
      sin_angle <= '0;
      cos_angle <= '0;
      v_q <= '0;
      g_q <= '0;
    end else if (en) begin
      p_q <= 37'((72'(angle) * 72'(INV_TWO_PI_Q)) >>> 31);
      a1_q <= angle;
      a2_q <= a1_q;
      a3_q <= a2_q;
      k_q <= k;
      kt_q <= k_q * TWO_PI_Q;
      r_q <= a3_q - kt_q;
      rc_q <= rc;
      sin_angle <= rc_q;
      cos_angle <= cw;
      v_q <= {v_q[4:0], in_valid};
      g_q <= {g_q[4:0], rng};
    end
  end
endmodule

// File: tb/tb_angle_reduce.sv
// tb_angle_reduce: self-checking bench for angle_reduce against a real-valued reduction model
module tb_angle_reduce;
  typedef struct {
    logic v;
    logic signed [35:0] a;
    logic ex;
    logic signed [35:0] es;
    logic signed [35:0] ec;
  } ent_t;
  localparam real TW = 2.0 * 3.141592653589793 * 65536.0;
  localparam real HP = 3.141592653589793 * 65536.0 / 2.0;
  logic clk = 0, rst = 0, en = 0, in_valid = 0;
  logic signed [35:0] angle = 0;
  logic signed [35:0] sin_angle, cos_angle;
  logic out_valid, out_range;
  int errs = 0, checks = 0;
  ent_t q[$];
  angle_reduce dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .angle(angle),
    .out_valid(out_valid), .sin_angle(sin_angle), .cos_angle(cos_angle), .out_range(out_range)
  );
  always #5 clk = ~clk;
  function automatic real merr(input logic signed [35:0] got, input real want);
    real d;
    d = $itor(got) - want;
    d = d - TW * $floor(d / TW + 0.5);
    return d < 0.0 ? -d : d;
  endfunction
  function automatic logic signed [35:0] rin();
    return 36'($urandom_range(8388608, 0)) - 36'sd4194304;
  endfunction
  function automatic logic signed [35:0] rbig();
    return 36'($signed($urandom()));
  endfunction
  task automatic chk(input string tag, input logic signed [35:0] obs, input logic signed [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tol(input string tag, input logic signed [35:0] obs, input real want, input real lim);
    checks++;
    assert (merr(obs, want) <= lim) else begin
      errs++;
      $error("FAIL %s: got %0d expected %0.2f within %0.1f LSB mod 2pi", tag, obs, want, lim);
    end
  endtask
  task automatic inb(input string tag, input logic signed [35:0] obs);
    checks++;
    assert (obs >= -36'sd205887 && obs < 36'sd205887) else begin
      errs++;
      $error("FAIL %s: got %0d expected within [-205887,205887)", tag, obs);
    end
  endtask
  task automatic step(input logic r, input logic e, input logic v, input logic signed [35:0] a,
                      input logic ex = 0, input logic signed [35:0] es = 0, input logic signed [35:0] ec = 0);
    ent_t n, o;
    logic pv, pg, rg;
    logic signed [35:0] ps, pc;
    pv = out_valid; pg = out_range; ps = sin_angle; pc = cos_angle;
    rst = r; en = e; in_valid = v; angle = a;
    @(posedge clk);
    #1;
    if (r) begin
      q.delete();
      n = '{v: 1'b0, a: '0, ex: 1'b0, es: '0, ec: '0};
      repeat (6) q.push_back(n);
      chk("rst_valid", out_valid, 0);
      chk("rst_range", out_range, 0);
      chk("rst_sin", sin_angle, 0);
      chk("rst_cos", cos_angle, 0);
    end else if (!e) begin
      chk("hold_valid", out_valid, pv);
      chk("hold_range", out_range, pg);
      chk("hold_sin", sin_angle, ps);
      chk("hold_cos", cos_angle, pc);
    end else begin
      n = '{v: v, a: a, ex: ex, es: es, ec: ec};
      q.push_back(n);
      void'(q.pop_front());
      o = q[0];
      chk("valid", out_valid, o.v);
      if (o.v) begin
        rg = o.a > 36'sd4194304 || o.a < -36'sd4194304;
        chk("range", out_range, rg);
        if (!rg && o.ex) begin
          chk("sin_exact", sin_angle, o.es);
          chk("cos_exact", cos_angle, o.ec);
        end else if (!rg) begin
          tol("sin_err", sin_angle, $itor(o.a), 4.0);
          tol("cos_err", cos_angle, $itor(o.a) + HP, 5.0);
          inb("sin_bound", sin_angle);
          inb("cos_bound", cos_angle);
        end
      end
    end
  endtask
  initial begin
    step(1, 1, 0, 0);
    step(1, 0, 1, 36'sd1000);
    step(0, 1, 1, 0, 1, 0, 36'sd102944);
    step(0, 1, 1, 36'sd458752, 1, 36'sd46977, 36'sd149921);
    step(0, 1, 1, -36'sd205887, 1, -36'sd205887, -36'sd102943);
    step(0, 1, 1, 36'sd205887, 1, -36'sd205888, -36'sd102944);
    step(0, 1, 1, 36'sd102943, 1, 36'sd102943, -36'sd205888);
    step(0, 1, 1, 36'sd102942, 1, 36'sd102942, 36'sd205886);
    step(0, 1, 1, 36'sd411775, 1, 0, 36'sd102944);
    step(0, 1, 1, 36'sd4194304);
    step(0, 1, 1, 36'sd16777216);
    step(0, 1, 1, -36'sd4194304);
    step(0, 1, 1, 36'sd4194305);
    step(0, 1, 1, -36'sd16777216);
    repeat (8) step(0, 1, 0, 0);
    repeat (10) step(0, 1, 1, rin());
    repeat (3) step(0, 0, 1, rin());
    repeat (10) step(0, 1, 1, rin());
    repeat (8) step(0, 1, 0, rin());
    repeat (4) step(0, 1, 1, rin());
    step(1, 1, 1, rin());
    repeat (8) step(0, 1, 0, rin());
    repeat (3) step(0, 1, 1, rin());
    step(1, 0, 1, rin());
    repeat (8) step(0, 1, 0, rin());
    repeat (600) step(0, $urandom_range(4, 0) != 0, 1'($urandom_range(1, 0)),
                      $urandom_range(7, 0) == 0 ? rbig() : rin());
    repeat (8) step(0, 1, 0, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
